// File: rtl/uart_rx_axis.sv
// UART receiver: 8N1-style frames of DATA_WIDTH bits, LSB first, mid-bit sampled,
// delivered on an AXI-stream master with overrun and framing error pulses.
`timescale 1ns/1ps
module uart_rx_axis #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int BW = $clog2(DATA_WIDTH + 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                  rxd_meta_reg, rxd_s_reg;
  state_t                state_reg, state_next;
  logic [18:0]           cnt_reg, cnt_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [15:0]           p_reg, p_next;
  logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
  logic                  tvalid_reg, tvalid_next;
  logic                  overrun_reg, overrun_next;
  logic                  frame_err_reg, frame_err_next;

  logic [15:0] p_in;
  logic [18:0] half_in, full_period;

  // A zero prescale would give a zero-length bit; clamp it to one unit.
  assign p_in        = (prescale == 16'd0) ? 16'd1 : prescale;
  assign half_in     = {1'b0, p_in, 2'b00} - 19'd1;
  assign full_period = {p_reg, 3'b000} - 19'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_s_reg    <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_s_reg    <= rxd_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      p_reg         <= '0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      p_reg         <= p_next;
      tdata_reg     <= tdata_next;
      tvalid_reg    <= tvalid_next;
      overrun_reg   <= overrun_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    p_next         = p_reg;
    tdata_next     = tdata_reg;
    tvalid_next    = tvalid_reg;
    overrun_next   = 1'b0;
    frame_err_next = 1'b0;

    if (tvalid_reg && m_axis_tready) tvalid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rxd_s_reg) begin
          p_next     = p_in;
          cnt_next   = half_in;
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg != 19'd0) begin
          cnt_next = cnt_reg - 19'd1;
        end else if (rxd_s_reg) begin
          state_next = IDLE;
        end else begin
          cnt_next     = full_period;
          bit_cnt_next = BW'(DATA_WIDTH);
          state_next   = DATA;
        end
      end
      DATA: begin
        if (cnt_reg != 19'd0) begin
          cnt_next = cnt_reg - 19'd1;
        end else begin
          shift_next   = {rxd_s_reg, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt_next = bit_cnt_reg - BW'(1);
          cnt_next     = full_period;
          if (bit_cnt_reg == BW'(1)) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg != 19'd0) begin
          cnt_next = cnt_reg - 19'd1;
        end else begin
          // A word written during a handshake cycle replaces the consumed one cleanly.
          if (rxd_s_reg) begin
            tdata_next   = shift_reg;
            tvalid_next  = 1'b1;
            overrun_next = tvalid_reg && !m_axis_tready;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign busy          = (state_reg != IDLE);
  assign overrun_error = overrun_reg;
  assign frame_error   = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: a 16-bit instance for protocol corner cases and
// an 8-bit instance fed by a behavioural transmitter for a 256-byte loopback stream.
`timescale 1ns/1ps
module tb_uart_rx_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd16 = 1'b1, tready16 = 1'b1;
  logic        rxd8 = 1'b1, tready8 = 1'b1;
  logic [15:0] prescale16 = 16'd1;
  logic [15:0] prescale8 = 16'd3;
  logic [15:0] tdata16;
  logic [7:0]  tdata8;
  logic        tvalid16, busy16, ovr16, fe16;
  logic        tvalid8, busy8, ovr8, fe8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats16 = 0, beats8 = 0;
  int fe16_n = 0, ovr16_n = 0, fe8_n = 0, ovr8_n = 0;
  int rise16_cyc = -1;
  logic [31:0] exp16_q[$];
  logic [31:0] exp8_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_axis #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata16), .m_axis_tvalid(tvalid16), .m_axis_tready(tready16),
    .rxd(rxd16), .busy(busy16), .overrun_error(ovr16), .frame_error(fe16),
    .prescale(prescale16)
  );

  uart_rx_axis #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready8),
    .rxd(rxd8), .busy(busy8), .overrun_error(ovr8), .frame_error(fe8),
    .prescale(prescale8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural transmitter: start bit, data LSB first, stop bit, each p*8 clocks.
  task automatic send_frame(input int sel, input logic [31:0] word, input int width,
                            input int p, input logic stop_bit);
    logic b;
    for (int i = 0; i < width + 2; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= width) b = word[i-1];
      else b = stop_bit;
      if (sel == 0) rxd16 = b; else rxd8 = b;
      tick(p * 8);
    end
    if (sel == 0) rxd16 = 1'b1; else rxd8 = 1'b1;
  endtask

  // Scoreboard: every accepted beat must match the next word the bench expects.
  task automatic monitor();
    logic tv16_prev = 1'b0, fe16_prev = 1'b0, ovr16_prev = 1'b0;
    logic fe8_prev = 1'b0, ovr8_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tvalid16 && tready16) begin
          beats16++;
          if (exp16_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat16: got word %h required no word", tdata16);
          end else chk("beat16", 32'(tdata16), exp16_q.pop_front());
        end
        if (tvalid8 && tready8) begin
          beats8++;
          if (exp8_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat8: got word %h required no word", tdata8);
          end else chk("beat8", 32'(tdata8), exp8_q.pop_front());
        end
        if (tvalid16 && !tv16_prev && rise16_cyc < 0) rise16_cyc = cyc;
        if (fe16)  begin fe16_n++;  chk("fe16_single_cycle",  32'(fe16_prev),  0); end
        if (ovr16) begin ovr16_n++; chk("ovr16_single_cycle", 32'(ovr16_prev), 0); end
        if (fe8)   begin fe8_n++;   chk("fe8_single_cycle",   32'(fe8_prev),   0); end
        if (ovr8)  begin ovr8_n++;  chk("ovr8_single_cycle",  32'(ovr8_prev),  0); end
      end
      tv16_prev  = tvalid16;
      fe16_prev  = fe16;
      ovr16_prev = ovr16;
      fe8_prev   = fe8;
      ovr8_prev  = ovr8;
    end
  endtask

  task automatic run_tests();
    int start_cyc, lat, d;
    logic [15:0] w;
    logic [7:0]  b;

    tick(3);
    chk("reset_tdata",   32'(tdata16),  0);
    chk("reset_tvalid",  32'(tvalid16), 0);
    chk("reset_busy",    32'(busy16),   0);
    chk("reset_overrun", 32'(ovr16),    0);
    chk("reset_frame",   32'(fe16),     0);
    rst = 1'b0;
    tick(5);

    // Clean frame; also measures start-edge to tvalid latency.
    start_cyc = cyc;
    exp16_q.push_back(32'h0000A5C3);
    send_frame(0, 32'h0000A5C3, 16, 1, 1'b1);
    tick(10);
    lat = 2 + 4 + 16 * 8 + 8 + 1;
    d = rise16_cyc - start_cyc;
    checks++;
    if (d < lat - 1 || d > lat + 1) begin
      errors++;
      $display("FAIL t1_latency: got %0d cycles required %0d+-1", d, lat);
    end
    chk("t1_beats",   32'(beats16), 1);
    chk("t1_tdata",   32'(tdata16), 32'h0000A5C3);
    chk("t1_tvalid",  32'(tvalid16), 0);
    chk("t1_fe",      32'(fe16_n),  0);
    chk("t1_ovr",     32'(ovr16_n), 0);

    // Two-clock glitch: START must reject it silently.
    rxd16 = 1'b0;
    tick(2);
    rxd16 = 1'b1;
    tick(3);
    chk("t2_busy_during", 32'(busy16), 1);
    tick(20);
    chk("t2_busy_after",  32'(busy16),   0);
    chk("t2_beats",       32'(beats16),  1);
    chk("t2_tvalid",      32'(tvalid16), 0);
    chk("t2_fe",          32'(fe16_n),   0);
    chk("t2_ovr",         32'(ovr16_n),  0);

    // Stop bit low: word dropped, frame error pulse.
    send_frame(0, 32'h00001234, 16, 1, 1'b0);
    tick(20);
    chk("t3_fe",     32'(fe16_n),   1);
    chk("t3_tvalid", 32'(tvalid16), 0);
    chk("t3_tdata",  32'(tdata16),  32'h0000A5C3);
    chk("t3_beats",  32'(beats16),  1);

    // Overrun: second word overwrites the first while tready is low.
    tready16 = 1'b0;
    exp16_q.push_back(32'h00000002);
    send_frame(0, 32'h00000001, 16, 1, 1'b1);
    send_frame(0, 32'h00000002, 16, 1, 1'b1);
    tick(5);
    chk("t4_ovr",    32'(ovr16_n),  1);
    chk("t4_tvalid", 32'(tvalid16), 1);
    chk("t4_tdata",  32'(tdata16),  32'h00000002);
    chk("t4_beats",  32'(beats16),  1);
    tready16 = 1'b1;
    tick(5);
    chk("t4_beats_after",  32'(beats16),  2);
    chk("t4_tvalid_after", 32'(tvalid16), 0);

    // Reset in the middle of data bit 7, then a clean frame.
    w = 16'h5555;
    rxd16 = 1'b0;
    tick(8);
    for (int i = 0; i < 7; i++) begin
      rxd16 = w[i];
      tick(8);
    end
    rxd16 = w[7];
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("t5_tdata",  32'(tdata16),  0);
    chk("t5_tvalid", 32'(tvalid16), 0);
    chk("t5_busy",   32'(busy16),   0);
    chk("t5_fe",     32'(fe16),     0);
    chk("t5_ovr",    32'(ovr16),    0);
    rst = 1'b0;
    rxd16 = 1'b1;
    tick(10);
    exp16_q.push_back(32'h0000BEEF);
    send_frame(0, 32'h0000BEEF, 16, 1, 1'b1);
    tick(10);
    chk("t5_beats",  32'(beats16), 3);
    chk("t5_tdata_after", 32'(tdata16), 32'h0000BEEF);
    chk("t5_pending", 32'(exp16_q.size()), 0);
    chk("t5_fe_count", 32'(fe16_n), 1);

    // Loopback stream into the 8-bit receiver, frames back to back.
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      exp8_q.push_back(32'(b));
      send_frame(1, 32'(b), 8, 3, 1'b1);
    end
    tick(30);
    chk("t6_beats",   32'(beats8), 256);
    chk("t6_pending", 32'(exp8_q.size()), 0);
    chk("t6_fe",      32'(fe8_n),  0);
    chk("t6_ovr",     32'(ovr8_n), 0);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
- UART receiver that consumes the serial line driven by the team's AXI-stream UART transmitter and presents each received word on an AXI-stream master.
- Frame format matches the transmitter: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1).
- Bit period is prescale*8 clk cycles. Each bit is sampled once, at its mid-point.
- Sits at the RX end of the serial link, feeding downstream consumers (FIFO, command parser).

Parameters:
- DATA_WIDTH, 16, data bits per frame. Legal range 5..32.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- m_axis_tdata  output  DATA_WIDTH  received word
- m_axis_tvalid  output  1  tdata holds an unconsumed word
- m_axis_tready  input  1  downstream accepts word
- rxd  input  1  serial line, asynchronous to clk, idle high
- busy  output  1  frame reception in progress
- overrun_error  output  1  one-cycle pulse: word completed while previous word unconsumed
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- prescale  input  16  bit period = prescale*8 clk cycles

Behaviour:
- Reset values (all outputs and state):
  - m_axis_tdata=0, m_axis_tvalid=0, busy=0, overrun_error=0, frame_error=0.
  - Synchronizer flops=1, state=IDLE, all counters 0.
- rxd passes through a 2-flop synchronizer before any use. rxd_s is the synchronized value; it adds 2 cycles of fixed latency.
- Counters:
  - Prescale counter: 19 bits.
  - Bit counter: $clog2(DATA_WIDTH+2) bits. It must hold DATA_WIDTH+1 without wrap for every legal DATA_WIDTH.
- prescale is captured into an internal register on start detection. Changes mid-frame have no effect until the next frame.
- prescale=0 is treated as prescale=1.
- State IDLE:
  - busy=0.
  - rxd_s==0 -> load prescale counter with (P*4)-1, where P is the captured prescale. Go to START; busy=1 from the next cycle.
- State START:
  - Count down to 0, then sample rxd_s (mid-start-bit).
  - Sample 1 -> false start: go to IDLE, busy=0, no error flags.
  - Sample 0 -> load (P*8)-1, bit counter=DATA_WIDTH, go to DATA.
- State DATA:
  - Each time the prescale counter reaches 0: shift rxd_s into the MSB of the shift register (shift right), decrement the bit counter, reload (P*8)-1.
  - After the DATA_WIDTH-th sample -> go to STOP with (P*8)-1 loaded.
- State STOP, when the counter reaches 0, sample rxd_s:
  - Sample 1: m_axis_tdata<=shift register, m_axis_tvalid<=1. If m_axis_tvalid was already 1 and m_axis_tready was 0 in that same cycle, overrun_error pulses 1 cycle and the old word is overwritten.
  - Sample 0: frame_error pulses 1 cycle. tdata/tvalid are unchanged and the word is dropped.
  - Either outcome: go to IDLE, busy=0 next cycle.
- After STOP, IDLE does not require rxd_s to return high before arming. A line held low re-triggers START, and that frame's own START check filters it.
- Handshake:
  - m_axis_tvalid && m_axis_tready -> tvalid<=0 next cycle.
  - If a new word is written in the same cycle as the handshake, tvalid stays 1 with the new data and no overrun is flagged.
  - tdata is stable while tvalid=1 and no new word is written.
- Latency: the stop-bit mid-sample occurs (P*4) + DATA_WIDTH*(P*8) + (P*8) + ~1 cycles after rxd_s falls. tvalid rises on the cycle after that sample.
- Reset mid-frame aborts reception immediately. No tvalid or error flags are produced for the aborted frame.

Test Plan:
- DATA_WIDTH=16, prescale=1 (8 clk/bit): drive frame 0xA5C3 LSB first with stop bit 1, tready=1 -> exactly one tvalid beat, tdata=0xA5C3, no error pulses. Checks that a 16+2-bit frame is not truncated by bit-counter wrap.
- Glitch: rxd low for 2 clk, then high -> START rejects it, busy returns to 0, no tvalid, no error flags.
- Stop bit forced 0 on frame 0x1234 -> frame_error single-cycle pulse, tvalid stays 0, tdata unchanged.
- tready=0; send 0x0001 then 0x0002 -> second completion pulses overrun_error once, tdata=0x0002, tvalid=1. Then raise tready -> one beat, then tvalid=0.
- Assert rst for 1 cycle mid-data-bit 7 of a frame -> all outputs return to reset values. A following clean frame 0xBEEF is received correctly.
- Loopback: DATA_WIDTH=8, transmitter txd -> rxd, prescale=3, 256 random bytes streamed back-to-back -> all bytes received in order, zero error pulses.
